// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable data width, parity and stop bits.
// A one-deep holding register lets back-to-back frames leave the line with no idle gap.
module uart_tx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 1155,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 osc_clk,
  input  logic                 i_Rst,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      CLKS_PER_BIT < 2) begin : gen_bad_params
    $error("uart_tx_cfg: invalid parameter combination");
  end

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  par_q, par_d;
  logic                  serial_q, serial_d;
  logic                  active_q, active_d;
  logic                  done_q, done_d;

  logic                  xfer, bit_end, load;
  logic [DATA_BITS-1:0]  load_data;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  assign xfer    = i_Tx_DV & ~hold_full_q;
  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    par_d       = par_q;
    serial_d    = serial_q;
    active_d    = active_q;
    done_d      = 1'b0;
    load        = 1'b0;
    load_data   = hold_q;

    if (xfer) begin
      hold_d      = i_Tx_Byte;
      hold_full_d = 1'b1;
    end

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (hold_full_q) begin
          load        = 1'b1;
          hold_full_d = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d  = StData;
          idx_d    = '0;
          serial_d = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          idx_d = '0;
          if (idx_q == DataLast) begin
            state_d  = (PARITY != 0) ? StParity : StStop;
            serial_d = (PARITY != 0) ? par_q : 1'b1;
          end else begin
            idx_d    = idx_q + 4'd1;
            serial_d = shift_q[1];
            shift_d  = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d  = StStop;
          idx_d    = '0;
          serial_d = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (idx_q == StopLast) begin
            done_d = 1'b1;
            // A byte arriving on the last stop cycle bypasses the holding register.
            if (hold_full_q || xfer) begin
              load        = 1'b1;
              load_data   = hold_full_q ? hold_q : i_Tx_Byte;
              hold_full_d = 1'b0;
            end else begin
              state_d  = StIdle;
              active_d = 1'b0;
              serial_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d  = StStart;
      cnt_d    = '0;
      idx_d    = '0;
      shift_d  = load_data;
      par_d    = parity_of(load_data);
      serial_d = 1'b0;
      active_d = 1'b1;
    end
  end

  always_ff @(posedge osc_clk) begin
    if (i_Rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      serial_q    <= 1'b1;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      serial_q    <= serial_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  assign o_Tx_Ready  = ~hold_full_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations checked each cycle against a per-cycle line model
// built from frame bit lists, plus hand-computed waveform points.
module tb_uart_tx_cfg;

  function automatic int unsigned cfg_clk(input int g);
    case (g) 0: return 4; 1: return 4; 2: return 3; default: return 2; endcase
  endfunction
  function automatic int unsigned cfg_db(input int g);
    case (g) 0: return 8; 1: return 7; 2: return 7; default: return 9; endcase
  endfunction
  function automatic int unsigned cfg_par(input int g);
    case (g) 0: return 0; 1: return 2; 2: return 1; default: return 0; endcase
  endfunction
  function automatic int unsigned cfg_stop(input int g);
    case (g) 3: return 2; default: return 1; endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dv, rdy, act, ser, done;
  logic [8:0] tx_byte [4];
  logic       chk_en;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned Db = cfg_db(g);
    uart_tx_cfg #(
      .CLKS_PER_BIT(cfg_clk(g)),
      .DATA_BITS   (Db),
      .PARITY      (cfg_par(g)),
      .STOP_BITS   (cfg_stop(g))
    ) u_dut (
      .osc_clk    (clk),
      .i_Rst      (rst),
      .i_Tx_DV    (dv[g]),
      .i_Tx_Byte  (tx_byte[g][Db-1:0]),
      .o_Tx_Ready (rdy[g]),
      .o_Tx_Active(act[g]),
      .o_Tx_Serial(ser[g]),
      .o_Tx_Done  (done[g])
    );
  end

  task automatic chk(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // Model: each instance's line is a queue of per-cycle levels for the frame in progress.
  bit         line_q [4][$];
  bit         m_full [4];
  logic [8:0] m_hold [4];
  bit         m_done [4];

  task automatic push_frame(input int i, input logic [8:0] d);
    bit bits[$];
    bit p;
    bits.push_back(1'b0);
    p = 1'b0;
    for (int k = 0; k < int'(cfg_db(i)); k++) begin
      bits.push_back(d[k]);
      p ^= d[k];
    end
    if (cfg_par(i) != 0) bits.push_back((cfg_par(i) == 1) ? ~p : p);
    for (int s = 0; s < int'(cfg_stop(i)); s++) bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int c = 0; c < int'(cfg_clk(i)); c++) line_q[i].push_back(bits[b]);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      bit xfer;
      bit took;
      xfer      = dv[i] && !m_full[i];
      took      = 1'b0;
      m_done[i] = 1'b0;
      if (rst) begin
        line_q[i].delete();
        m_full[i] = 1'b0;
      end else begin
        if (line_q[i].size() > 0) begin
          void'(line_q[i].pop_front());
          if (line_q[i].size() == 0) begin
            m_done[i] = 1'b1;
            if (m_full[i]) begin
              push_frame(i, m_hold[i]);
              m_full[i] = 1'b0;
            end else if (xfer) begin
              push_frame(i, tx_byte[i]);
              took = 1'b1;
            end
          end
        end else if (m_full[i]) begin
          push_frame(i, m_hold[i]);
          m_full[i] = 1'b0;
        end
        if (xfer && !took) begin
          m_hold[i] = tx_byte[i];
          m_full[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("u%0d serial", i), ser[i], (line_q[i].size() > 0) ? line_q[i][0] : 1);
        chk($sformatf("u%0d active", i), act[i], line_q[i].size() > 0);
        chk($sformatf("u%0d done", i), done[i], m_done[i]);
        chk($sformatf("u%0d ready", i), rdy[i], !m_full[i]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_wait(input int i, input logic [8:0] d);
    bit ok;
    ok         = 1'b0;
    dv[i]      = 1'b1;
    tx_byte[i] = d;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (rdy[i]) ok = 1'b1;
      tick(1);
    end
    dv[i] = 1'b0;
    chk("accept", ok, 1);
  endtask

  initial begin
    logic [9:0] exp_a5;
    int ndone, gaps, cyc, busy;
    exp_a5 = 10'b1101001010;
    rst    = 1'b1;
    dv     = '0;
    chk_en = 1'b0;
    for (int i = 0; i < 4; i++) tx_byte[i] = '0;
    tick(2);
    chk_en = 1'b1;
    chk("reset serial", ser[0], 1);
    chk("reset active", act[0], 0);
    chk("reset ready", rdy[0], 1);
    chk("reset done", done[0], 0);
    rst = 1'b0;
    tick(2);

    // 8'hA5 at 4 clocks per bit
    tx_byte[0] = 9'h0A5;
    dv[0]      = 1'b1;
    tick(1);
    dv[0] = 1'b0;
    chk("t1 ready low", rdy[0], 0);
    tick(1);
    chk("t1 start serial", ser[0], 0);
    chk("t1 start active", act[0], 1);
    tick(1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t1 bit%0d", k), ser[0], exp_a5[k]);
      if (k < 9) tick(4);
    end
    tick(2);
    chk("t1 done early", done[0], 0);
    tick(1);
    chk("t1 done", done[0], 1);
    chk("t1 idle", act[0], 0);

    // 7'h07 with even (u1, 4 clk) and odd (u2, 3 clk) parity
    tx_byte[1] = 9'h007;
    tx_byte[2] = 9'h007;
    dv[1]      = 1'b1;
    dv[2]      = 1'b1;
    tick(1);
    dv[1] = 1'b0;
    dv[2] = 1'b0;
    tick(26);
    chk("t2 odd parity", ser[2], 0);
    tick(5);
    chk("t2 odd done", done[2], 1);
    tick(3);
    chk("t2 even parity", ser[1], 1);
    tick(7);
    chk("t2 even done", done[1], 1);

    // 9'h1FF with two stop bits at 2 clocks per bit
    tx_byte[3] = 9'h1FF;
    dv[3]      = 1'b1;
    tick(1);
    dv[3] = 1'b0;
    tick(2);
    chk("t4 start", ser[3], 0);
    tick(2);
    chk("t4 data", ser[3], 1);
    tick(20);
    chk("t4 stop2", ser[3], 1);
    chk("t4 not done", done[3], 0);
    tick(1);
    chk("t4 done", done[3], 1);
    chk("t4 idle", act[3], 0);

    // Back-to-back frames
    send_wait(0, 9'h055);
    send_wait(0, 9'h00F);
    ndone = 0;
    gaps  = 0;
    cyc   = 0;
    while (ndone < 2 && cyc < 300) begin
      tick(1);
      cyc++;
      if (done[0]) ndone++;
      if (!act[0] && ndone < 2) gaps++;
    end
    chk("t3 dones", ndone, 2);
    chk("t3 gaps", gaps, 0);
    chk("t3 length", cyc, 79);

    // Reset mid-frame with a byte buffered
    send_wait(0, 9'h0C3);
    send_wait(0, 9'h03C);
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5 serial", ser[0], 1);
    chk("t5 active", act[0], 0);
    chk("t5 ready", rdy[0], 1);
    chk("t5 done", done[0], 0);
    busy = 0;
    for (int c = 0; c < 60; c++) begin
      tick(1);
      if (act[0] || done[0]) busy++;
    end
    chk("t5 no frame", busy, 0);

    // Byte offered while not ready is dropped
    send_wait(0, 9'h0AA);
    tx_byte[0] = 9'h011;
    dv[0]      = 1'b1;
    tick(1);
    dv[0] = 1'b0;
    tick(5);
    chk("t6 first data bit", ser[0], 0);
    tick(40);
    chk("t6 single frame", act[0], 0);

    // Random traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        dv[i]      = ($urandom_range(0, 2) == 0);
        tx_byte[i] = 9'($urandom);
      end
      rst = ($urandom_range(0, 699) == 0);
      tick(1);
    end
    dv  = '0;
    rst = 1'b0;
    tick(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
